// File: rtl/countdown_timer_mmss_if.sv
// Control and display bundle for the MM:SS countdown timer.
// The controller side (master) drives the keys/tick, the timer (slave) drives the digits.
interface countdown_timer_mmss_if;
  logic       tick;
  logic       load;
  logic [3:0] min_t_in;
  logic [3:0] min_u_in;
  logic [3:0] sec_t_in;
  logic [3:0] sec_u_in;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic       running;
  logic       done;
  logic       done_pulse;

  modport master (
    output tick, load, min_t_in, min_u_in, sec_t_in, sec_u_in, start, pause, clear,
    input  min_t, min_u, sec_t, sec_u, running, done, done_pulse
  );

  modport slave (
    input  tick, load, min_t_in, min_u_in, sec_t_in, sec_u_in, start, pause, clear,
    output min_t, min_u, sec_t, sec_u, running, done, done_pulse
  );
endinterface

// File: rtl/countdown_timer_mmss.sv
// MM:SS BCD countdown: decrements the loaded time once every TICKS_PER_SEC tick pulses
// and drives the display digits, magnetron enable and end-of-cook signals.
module countdown_timer_mmss #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  countdown_timer_mmss_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  localparam logic [9:0] PRESC_LAST = 10'(TICKS_PER_SEC - 1);

  state_t     state_reg, state_next;
  logic [9:0] presc_reg, presc_next;
  logic       done_pulse_reg, done_pulse_next;

  // Digit index 0 = sec_u, 1 = sec_t, 2 = min_u, 3 = min_t.
  logic [3:0] digit_reg   [4];
  logic [3:0] digit_next  [4];
  logic [3:0] raw_in      [4];
  logic [3:0] load_digit  [4];
  logic [3:0] dec_digit   [4];
  logic       borrow_in   [4];
  logic [3:0] is_zero;
  logic       count_zero;
  logic       count_one;

  assign raw_in[0] = bus.sec_u_in;
  assign raw_in[1] = bus.sec_t_in;
  assign raw_in[2] = bus.min_u_in;
  assign raw_in[3] = bus.min_t_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      // Seconds tens rolls over at 5, every other digit at 9.
      localparam logic [3:0] DIGIT_MAX = (gi == 1) ? 4'd5 : 4'd9;

      assign is_zero[gi]    = (digit_reg[gi] == 4'd0);
      assign load_digit[gi] = (raw_in[gi] > DIGIT_MAX) ? DIGIT_MAX : raw_in[gi];

      if (gi == 0) begin : g_lsd
        assign borrow_in[gi] = 1'b1;
      end else begin : g_upper
        assign borrow_in[gi] = &is_zero[gi-1:0];
      end

      assign dec_digit[gi] = !borrow_in[gi] ? digit_reg[gi] :
                             is_zero[gi]    ? DIGIT_MAX     :
                                              digit_reg[gi] - 4'd1;
    end
  endgenerate

  assign count_zero = &is_zero;
  assign count_one  = (digit_reg[0] == 4'd1) && (&is_zero[3:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      presc_reg      <= '0;
      done_pulse_reg <= 1'b0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      done_pulse_reg <= done_pulse_next;
      for (int i = 0; i < 4; i++) digit_reg[i] <= digit_next[i];
    end
  end

  // Priority chain: clear > load > pause > start > tick. A command that is not
  // legal in the current state falls through to the next one.
  always_comb begin
    state_next      = state_reg;
    presc_next      = presc_reg;
    done_pulse_next = 1'b0;
    for (int i = 0; i < 4; i++) digit_next[i] = digit_reg[i];

    if (bus.clear) begin
      state_next = IDLE;
      presc_next = '0;
      for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
    end else if (bus.load && state_reg != RUNNING) begin
      state_next = IDLE;
      presc_next = '0;
      for (int i = 0; i < 4; i++) digit_next[i] = load_digit[i];
    end else if (bus.pause && state_reg == RUNNING) begin
      state_next = PAUSED;
    end else if (bus.start && (state_reg == IDLE || state_reg == PAUSED) && !count_zero) begin
      state_next = RUNNING;
      if (state_reg == IDLE) presc_next = '0;
    end else if (bus.tick && state_reg == RUNNING) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        for (int i = 0; i < 4; i++) digit_next[i] = dec_digit[i];
        if (count_one) begin
          state_next      = DONE;
          done_pulse_next = 1'b1;
        end
      end else begin
        presc_next = presc_reg + 10'd1;
      end
    end
  end

  assign bus.sec_u      = digit_reg[0];
  assign bus.sec_t      = digit_reg[1];
  assign bus.min_u      = digit_reg[2];
  assign bus.min_t      = digit_reg[3];
  assign bus.running    = (state_reg == RUNNING);
  assign bus.done       = (state_reg == DONE);
  assign bus.done_pulse = done_pulse_reg;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Bench for countdown_timer_mmss: two instances (1 and 100 ticks per second) checked
// every cycle against a seconds-based reference model, plus directed scenario checks.
module tb_countdown_timer_mmss;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_mmss_if bus0 ();
  countdown_timer_mmss_if bus1 ();

  assign bus1.tick     = bus0.tick;
  assign bus1.load     = bus0.load;
  assign bus1.min_t_in = bus0.min_t_in;
  assign bus1.min_u_in = bus0.min_u_in;
  assign bus1.sec_t_in = bus0.sec_t_in;
  assign bus1.sec_u_in = bus0.sec_u_in;
  assign bus1.start    = bus0.start;
  assign bus1.pause    = bus0.pause;
  assign bus1.clear    = bus0.clear;

  countdown_timer_mmss #(.TICKS_PER_SEC(1))   dut0 (.clk(clk), .rst(rst), .bus(bus0));
  countdown_timer_mmss #(.TICKS_PER_SEC(100)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: count held as total seconds, state as a small integer code.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_secs [2];
  int m_st   [2];
  int m_pre  [2];
  bit m_dp   [2];
  int tps    [2] = '{1, 100};

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic void model_step(input int k);
    m_dp[k] = 1'b0;
    if (rst || bus0.clear) begin
      m_secs[k] = 0; m_pre[k] = 0; m_st[k] = M_IDLE;
    end else if (bus0.load && m_st[k] != M_RUN) begin
      m_secs[k] = clamp(int'(bus0.min_t_in), 9) * 600 + clamp(int'(bus0.min_u_in), 9) * 60
                + clamp(int'(bus0.sec_t_in), 5) * 10 + clamp(int'(bus0.sec_u_in), 9);
      m_pre[k] = 0; m_st[k] = M_IDLE;
    end else if (bus0.pause && m_st[k] == M_RUN) begin
      m_st[k] = M_PAUSE;
    end else if (bus0.start && (m_st[k] == M_IDLE || m_st[k] == M_PAUSE) && m_secs[k] != 0) begin
      if (m_st[k] == M_IDLE) m_pre[k] = 0;
      m_st[k] = M_RUN;
    end else if (bus0.tick && m_st[k] == M_RUN) begin
      m_pre[k]++;
      if (m_pre[k] == tps[k]) begin
        m_pre[k] = 0;
        m_secs[k]--;
        if (m_secs[k] == 0) begin
          m_st[k] = M_DONE;
          m_dp[k] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [15:0] secs_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [18:0] model_out(input int k);
    return {secs_bcd(m_secs[k]), m_st[k] == M_RUN, m_st[k] == M_DONE, m_dp[k]};
  endfunction

  function automatic logic [15:0] digits0();
    return {bus0.min_t, bus0.min_u, bus0.sec_t, bus0.sec_u};
  endfunction

  function automatic logic [15:0] digits1();
    return {bus1.min_t, bus1.min_u, bus1.sec_t, bus1.sec_u};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_val("model0", {digits0(), bus0.running, bus0.done, bus0.done_pulse}, model_out(0));
    check_val("model1", {digits1(), bus1.running, bus1.done, bus1.done_pulse}, model_out(1));
  endtask

  task automatic idle_inputs();
    bus0.tick = 0; bus0.load = 0; bus0.start = 0; bus0.pause = 0; bus0.clear = 0;
  endtask

  task automatic do_clear();
    idle_inputs(); bus0.clear = 1; cycle(); idle_inputs();
  endtask

  task automatic do_load(input logic [15:0] v);
    idle_inputs(); bus0.load = 1;
    {bus0.min_t_in, bus0.min_u_in, bus0.sec_t_in, bus0.sec_u_in} = v;
    cycle(); idle_inputs();
  endtask

  task automatic do_start();
    idle_inputs(); bus0.start = 1; cycle(); idle_inputs();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs(); bus0.tick = 1; cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    {bus0.min_t_in, bus0.min_u_in, bus0.sec_t_in, bus0.sec_u_in} = 16'h0;
    rst = 1;
    cycle();
    check_val("reset_outputs", {digits0(), bus0.running, bus0.done, bus0.done_pulse}, 0);
    rst = 0;
    $display("txn reset");

    do_load(16'h0130); do_start(); do_ticks(1);
    check_val("0130_tick", digits0(), 16'h0129);
    check_val("0130_running", bus0.running, 1);
    $display("txn load 01:30 start tick -> %h", digits0());

    do_clear(); do_load(16'h1000); do_start(); do_ticks(1);
    check_val("borrow_chain", digits0(), 16'h0959);
    $display("txn load 10:00 start tick -> %h", digits0());

    do_clear(); do_load(16'h0002); do_start(); do_ticks(2);
    check_val("done_digits", digits0(), 16'h0000);
    check_val("done_pulse_hi", bus0.done_pulse, 1);
    check_val("done_level", bus0.done, 1);
    check_val("done_running", bus0.running, 0);
    idle_inputs(); bus0.tick = 1; bus0.start = 1; cycle(); idle_inputs();
    check_val("done_pulse_lo", bus0.done_pulse, 0);
    check_val("done_hold", {digits0(), bus0.done}, {16'h0000, 1'b1});
    $display("txn load 00:02 run to done");

    do_load(16'hFF7C);
    check_val("clamp", digits0(), 16'h9959);
    do_start();
    idle_inputs(); bus0.tick = 1; bus0.pause = 1; cycle(); idle_inputs();
    check_val("pause_wins", {digits0(), bus0.running, bus0.done}, {16'h9959, 2'b00});
    do_start(); do_ticks(1);
    check_val("resume_tick", digits0(), 16'h9958);
    $display("txn clamp/pause/resume -> %h", digits0());

    do_clear(); do_load(16'h0005); do_start(); do_ticks(99);
    check_val("tps100_99", digits1(), 16'h0005);
    do_ticks(1);
    check_val("tps100_100", digits1(), 16'h0004);
    idle_inputs(); bus0.pause = 1; cycle(); idle_inputs();
    do_start(); do_ticks(100);
    check_val("tps100_resume", digits1(), 16'h0003);
    $display("txn prescaler 100 -> %h", digits1());

    do_clear(); do_load(16'h0130); do_start(); do_ticks(1); do_clear();
    check_val("clear_run", {digits0(), bus0.running}, 17'h0);
    do_load(16'h0130); do_start(); do_ticks(1);
    rst = 1; cycle(); rst = 0;
    check_val("rst_run", {digits0(), bus0.running, bus0.done, bus0.done_pulse}, 19'h0);
    do_start();
    check_val("start_zero", bus0.running, 0);
    $display("txn clear/rst/start-zero");

    for (int t = 0; t < 4000; t++) begin
      rst        = ($urandom_range(0, 699) == 0);
      bus0.clear = ($urandom_range(0, 99) == 0);
      bus0.load  = ($urandom_range(0, 19) == 0);
      bus0.pause = ($urandom_range(0, 24) == 0);
      bus0.start = ($urandom_range(0, 7) == 0);
      bus0.tick  = ($urandom_range(0, 1) == 0);
      bus0.min_t_in = 4'($urandom_range(0, 2));
      bus0.min_u_in = 4'($urandom);
      bus0.sec_t_in = 4'($urandom);
      bus0.sec_u_in = 4'($urandom);
      if (bus0.load)
        $display("txn %0d load %h", t, {bus0.min_t_in, bus0.min_u_in, bus0.sec_t_in, bus0.sec_u_in});
      cycle();
    end
    rst = 0;
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
